// File: rtl/mem_share_ctrl.sv
// mem_share_ctrl
//   Owns a single-port byte memory. After reset it sweeps every word to
//   INIT_VAL. It then shares the memory between two requesters using
//   round-robin arbitration with a req/gnt handshake. Read data comes back
//   on a one-cycle-latency response channel qualified by a valid flag.
//
// Ports
//   clk, rst (async, active-low)
//   pX_req/pX_we/pX_addr/pX_wdata : request channel of port X (0/1)
//   pX_gnt                         : request accepted this cycle (combinational)
//   pX_rvalid/pX_rdata             : read response, one cycle after a read grant
//   init_done                      : init sweep finished
//   mem_addr/mem_we/mem_wdata      : to the memory pins
//   mem_rdata                      : from the memory (registered, 1-cycle read)
module mem_share_ctrl #(
  parameter int unsigned         ADDR_W   = 2,
  parameter int unsigned         DATA_W   = 8,
  parameter logic [DATA_W-1:0]   INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              init_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {INIT, SERVE} state_t;

  // All-ones address is the last word (DEPTH-1).
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state;
  logic [ADDR_W-1:0] init_cnt;
  logic [ADDR_W-1:0] last_addr;
  logic              rr_last;
  logic              rd_pending;
  logic              rd_owner;
  logic              g0;
  logic              g1;

  // Round-robin: a lone requester wins; on contention the port that was
  // not granted last time wins.
  always_comb begin
    g0 = (state == SERVE) && p0_req && (!p1_req || rr_last);
    g1 = (state == SERVE) && p1_req && (!p0_req || !rr_last);
  end

  // Sweep drive is qualified by rst so the memory pins read idle/zero
  // while reset is held, even though the state already sits in INIT.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = last_addr;
    mem_wdata = '0;
    if (state == INIT) begin
      if (rst) begin
        mem_we    = 1'b1;
        mem_addr  = init_cnt;
        mem_wdata = INIT_VAL;
      end
    end else if (g0) begin
      mem_we    = p0_we;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
    end else if (g1) begin
      mem_we    = p1_we;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= INIT;
      init_cnt   <= '0;
      last_addr  <= '0;
      rr_last    <= 1'b1;
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      last_addr  <= mem_addr;
      rd_pending <= 1'b0;
      case (state)
        INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == LAST_ADDR) begin
            state     <= SERVE;
            init_done <= 1'b1;
          end
        end
        SERVE: begin
          if (g0 || g1) begin
            rr_last    <= g1;
            rd_owner   <= g1;
            rd_pending <= g0 ? !p0_we : !p1_we;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // Response data is forced to zero on the port that does not own it.
  always_comb begin
    p0_gnt    = g0;
    p1_gnt    = g1;
    p0_rvalid = rd_pending && !rd_owner;
    p1_rvalid = rd_pending && rd_owner;
    p0_rdata  = p0_rvalid ? mem_rdata : '0;
    p1_rdata  = p1_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_share_ctrl.sv
module tb_mem_share_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: INIT_VAL = 0 ----------------
  logic       rst;
  logic       p0_req, p0_we, p1_req, p1_we;
  logic [1:0] p0_addr, p1_addr;
  logic [7:0] p0_wdata, p1_wdata;
  logic       p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, init_done, mem_we;
  logic [7:0] p0_rdata, p1_rdata, mem_wdata, mem_rdata;
  logic [1:0] mem_addr;

  mem_share_ctrl #(.ADDR_W(2), .DATA_W(8), .INIT_VAL(8'h00)) u_dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .init_done(init_done), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [7:0] mem_a [4];
  always @(posedge clk) begin
    if (mem_we) mem_a[mem_addr] <= mem_wdata;
    mem_rdata <= mem_a[mem_addr];
  end

  // ---------------- DUT B: INIT_VAL = 0x7F ----------------
  logic       b_rst;
  logic       b_p0_req, b_p0_we, b_p1_req, b_p1_we;
  logic [1:0] b_p0_addr, b_p1_addr;
  logic [7:0] b_p0_wdata, b_p1_wdata;
  logic       b_p0_gnt, b_p1_gnt, b_p0_rvalid, b_p1_rvalid, b_init_done, b_mem_we;
  logic [7:0] b_p0_rdata, b_p1_rdata, b_mem_wdata, b_mem_rdata;
  logic [1:0] b_mem_addr;

  mem_share_ctrl #(.ADDR_W(2), .DATA_W(8), .INIT_VAL(8'h7F)) u_dut_b (
    .clk(clk), .rst(b_rst),
    .p0_req(b_p0_req), .p0_we(b_p0_we), .p0_addr(b_p0_addr), .p0_wdata(b_p0_wdata),
    .p0_gnt(b_p0_gnt), .p0_rvalid(b_p0_rvalid), .p0_rdata(b_p0_rdata),
    .p1_req(b_p1_req), .p1_we(b_p1_we), .p1_addr(b_p1_addr), .p1_wdata(b_p1_wdata),
    .p1_gnt(b_p1_gnt), .p1_rvalid(b_p1_rvalid), .p1_rdata(b_p1_rdata),
    .init_done(b_init_done), .mem_addr(b_mem_addr), .mem_we(b_mem_we),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  logic [7:0] mem_b [4];
  always @(posedge clk) begin
    if (b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
    b_mem_rdata <= mem_b[b_mem_addr];
  end

  // ---------------- scoreboard ----------------
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  logic        pend0 = 1'b0;
  logic        pend1 = 1'b0;
  logic [7:0]  ref_mem [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_sb();
    q0.delete();
    q1.delete();
    pend0 = 1'b0;
    pend1 = 1'b0;
    for (int i = 0; i < 4; i++) ref_mem[i] = 8'h00;
  endtask

  // Called at the negedge where rst has just been released.
  task automatic sweep(input string nm);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] a;
      a = 2'(i);
      #2;
      chk({nm, " sweep we"},   mem_we, 1);
      chk({nm, " sweep addr"}, mem_addr, a);
      chk({nm, " sweep data"}, mem_wdata, 8'h00);
      chk({nm, " sweep gnt0"}, p0_gnt, 0);
      chk({nm, " sweep gnt1"}, p1_gnt, 0);
      chk({nm, " sweep done"}, init_done, 0);
      @(negedge clk);
    end
  endtask

  // One cycle: drive at negedge, sample 2 time units later, end on next negedge.
  task automatic step(input logic r0, input logic w0, input logic [1:0] a0, input logic [7:0] d0,
                      input logic r1, input logic w1, input logic [1:0] a1, input logic [7:0] d1,
                      input logic eg0, input logic eg1, input string nm);
    logic [7:0] e;
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    #2;
    chk({nm, " init_done"}, init_done, 1);
    chk({nm, " rvalid0"}, p0_rvalid, pend0);
    if (pend0) begin
      e = q0.pop_front();
      chk({nm, " rdata0"}, p0_rdata, e);
    end else chk({nm, " rdata0 idle"}, p0_rdata, 0);
    chk({nm, " rvalid1"}, p1_rvalid, pend1);
    if (pend1) begin
      e = q1.pop_front();
      chk({nm, " rdata1"}, p1_rdata, e);
    end else chk({nm, " rdata1 idle"}, p1_rdata, 0);
    chk({nm, " gnt0"}, p0_gnt, eg0);
    chk({nm, " gnt1"}, p1_gnt, eg1);
    pend0 = 1'b0;
    pend1 = 1'b0;
    if (eg0) begin
      chk({nm, " mem_we"}, mem_we, w0);
      chk({nm, " mem_addr"}, mem_addr, a0);
      if (w0) begin
        chk({nm, " mem_wdata"}, mem_wdata, d0);
        ref_mem[a0] = d0;
      end else begin
        q0.push_back(ref_mem[a0]);
        pend0 = 1'b1;
      end
    end else if (eg1) begin
      chk({nm, " mem_we"}, mem_we, w1);
      chk({nm, " mem_addr"}, mem_addr, a1);
      if (w1) begin
        chk({nm, " mem_wdata"}, mem_wdata, d1);
        ref_mem[a1] = d1;
      end else begin
        q1.push_back(ref_mem[a1]);
        pend1 = 1'b1;
      end
    end else chk({nm, " mem_we idle"}, mem_we, 0);
    @(negedge clk);
  endtask

  initial begin
    clear_sb();
    rst = 1'b0; b_rst = 1'b0;
    // both ports request reads from reset onward
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 2'd0; p0_wdata = 8'h00;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 2'd1; p1_wdata = 8'h00;
    b_p0_req = 1'b1; b_p0_we = 1'b0; b_p0_addr = 2'd3; b_p0_wdata = 8'h00;
    b_p1_req = 1'b1; b_p1_we = 1'b0; b_p1_addr = 2'd1; b_p1_wdata = 8'h00;
    #2;
    chk("rst gnt0", p0_gnt, 0);
    chk("rst gnt1", p1_gnt, 0);
    chk("rst rvalid0", p0_rvalid, 0);
    chk("rst rvalid1", p1_rvalid, 0);
    chk("rst rdata0", p0_rdata, 0);
    chk("rst rdata1", p1_rdata, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst init_done", init_done, 0);
    chk("b rst gnt0", b_p0_gnt, 0);

    @(negedge clk);
    rst = 1'b1;
    sweep("init1");

    // continuous reads from both ports: grants alternate starting with p0
    step(1, 0, 2'd0, 8'h00, 1, 0, 2'd1, 8'h00, 1, 0, "alt1");
    step(1, 0, 2'd0, 8'h00, 1, 0, 2'd1, 8'h00, 0, 1, "alt2");
    step(1, 0, 2'd0, 8'h00, 1, 0, 2'd1, 8'h00, 1, 0, "alt3");
    step(1, 0, 2'd0, 8'h00, 1, 0, 2'd1, 8'h00, 0, 1, "alt4");
    // p0 write then read-back, p1 idle
    step(1, 1, 2'd2, 8'hA5, 0, 0, 2'd0, 8'h00, 1, 0, "p0wr");
    step(1, 0, 2'd2, 8'h00, 0, 0, 2'd0, 8'h00, 1, 0, "p0rd");
    step(0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00, 0, 0, "idle1");
    // distinct data per address, then alternating reads
    step(0, 0, 2'd0, 8'h00, 1, 1, 2'd0, 8'h11, 0, 1, "p1wr");
    step(1, 1, 2'd3, 8'h22, 0, 0, 2'd0, 8'h00, 1, 0, "p0wr3");
    step(1, 0, 2'd3, 8'h00, 1, 0, 2'd0, 8'h00, 0, 1, "rd_a");
    step(1, 0, 2'd3, 8'h00, 1, 0, 2'd0, 8'h00, 1, 0, "rd_b");
    step(1, 0, 2'd3, 8'h00, 1, 0, 2'd0, 8'h00, 0, 1, "rd_c");
    step(1, 0, 2'd2, 8'h00, 0, 0, 2'd0, 8'h00, 1, 0, "rd_d");
    step(0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00, 0, 0, "idle2");

    // p0 read granted, then reset asserted before the transfer edge
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 2'd2;
    #2;
    chk("mid gnt0", p0_gnt, 1);
    #1 rst = 1'b0;
    #1;
    chk("mid gnt0 rst", p0_gnt, 0);
    chk("mid mem_we rst", mem_we, 0);
    chk("mid init_done rst", init_done, 0);
    @(posedge clk);
    #1;
    chk("mid rvalid0", p0_rvalid, 0);
    p0_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    clear_sb();
    sweep("init2");

    // first contention after reset: p0 read wins over p1 write
    step(1, 0, 2'd1, 8'h00, 1, 1, 2'd1, 8'h3C, 1, 0, "cont1");
    step(0, 0, 2'd1, 8'h00, 1, 1, 2'd1, 8'h3C, 0, 1, "cont2");
    step(1, 0, 2'd1, 8'h00, 0, 0, 2'd0, 8'h00, 1, 0, "cont3");
    step(1, 0, 2'd2, 8'h00, 0, 0, 2'd0, 8'h00, 1, 0, "cleared");
    step(0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00, 0, 0, "idle3");

    // DUT B: requests held across the whole init sweep
    b_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("b sweep gnt0", b_p0_gnt, 0);
      chk("b sweep gnt1", b_p1_gnt, 0);
      chk("b sweep data", b_mem_wdata, 8'h7F);
      @(negedge clk);
    end
    #2;
    chk("b init_done", b_init_done, 1);
    chk("b first gnt0", b_p0_gnt, 1);
    chk("b first gnt1", b_p1_gnt, 0);
    @(negedge clk);
    b_p0_req = 1'b0;
    #2;
    chk("b rvalid0", b_p0_rvalid, 1);
    chk("b rdata0", b_p0_rdata, 8'h7F);
    chk("b gnt1", b_p1_gnt, 1);
    @(negedge clk);
    b_p1_req = 1'b0;
    #2;
    chk("b rvalid1", b_p1_rvalid, 1);
    chk("b rdata1", b_p1_rdata, 8'h7F);
    chk("b rvalid0 off", b_p0_rvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
